// File: rtl/mips_mdu.sv
// mips_mdu: iterative MIPS multiply/divide unit that owns the architectural HI/LO registers.
// Define MIPS_MDU_DIV_EN to build the restoring divider; without it DIV/DIVU are no-ops.
module mips_mdu (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        StartE,
    input  logic [2:0]  MdOpE,
    input  logic [31:0] SrcAE,
    input  logic [31:0] SrcBE,
    input  logic        FlushE,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic        BusyE,
    output logic        DoneE
);
    localparam logic [2:0] OP_MTHI = 3'b100;
    localparam logic [2:0] OP_MTLO = 3'b101;

`ifdef MIPS_MDU_DIV_EN
    typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DIV = 2'd2, DONE = 2'd3} mduState_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DONE = 2'd3} mduState_t;
`endif

    mduState_t   stateReg, stateNext;
    logic        busyReg;
    logic [5:0]  cntReg;
    logic [63:0] accReg;
    logic [31:0] opndReg;
    logic        negLoReg;
    logic [31:0] hiReg, loReg;

    logic        accept, opSigned, startMul, lastIter;
    logic [31:0] magA, magB;
    logic [32:0] mulSum;
    logic [63:0] mulStep, accNeg;
    logic [31:0] resHi, resLo;

    assign accept   = (stateReg == IDLE) && StartE && !FlushE;
    assign opSigned = ~MdOpE[0];
    assign startMul = accept && (MdOpE[2:1] == 2'b00);
    assign lastIter = (cntReg == 6'd31);
    // Magnitudes of 0x80000000 wrap to 0x80000000, i.e. 2^31 as unsigned.
    assign magA = (opSigned && SrcAE[31]) ? 32'd0 - SrcAE : SrcAE;
    assign magB = (opSigned && SrcBE[31]) ? 32'd0 - SrcBE : SrcBE;

    // Shift-add: multiplier sits in the low half and is consumed LSB first.
    assign mulSum  = {1'b0, accReg[63:32]} + (accReg[0] ? {1'b0, opndReg} : 33'd0);
    assign mulStep = {mulSum, accReg[31:1]};
    assign accNeg  = 64'd0 - accReg;

`ifdef MIPS_MDU_DIV_EN
    logic        negHiReg, isDivReg;
    logic        startDiv, divByZero, geq;
    logic [32:0] trial;
    logic [31:0] remNext;
    logic [63:0] divStep;

    assign startDiv  = accept && (MdOpE[2:1] == 2'b01);
    assign divByZero = (SrcBE == 32'd0);
    // Restoring step: {remainder, dividend} shifts left one bit, quotient bit enters at LSB.
    assign trial     = accReg[63:31];
    assign geq       = (trial >= {1'b0, opndReg});
    assign remNext   = geq ? trial[31:0] - opndReg : trial[31:0];
    assign divStep   = {remNext, accReg[30:0], geq};

    always_comb begin
        if (isDivReg) begin
            resHi = negHiReg ? 32'd0 - accReg[63:32] : accReg[63:32];
            resLo = negLoReg ? 32'd0 - accReg[31:0]  : accReg[31:0];
        end else begin
            {resHi, resLo} = negLoReg ? accNeg : accReg;
        end
    end
`else
    assign {resHi, resLo} = negLoReg ? accNeg : accReg;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateReg <= IDLE;
            busyReg  <= 1'b0;
        end else begin
            stateReg <= stateNext;
            busyReg  <= (stateNext != IDLE);
        end
    end

    always_comb begin
        stateNext = stateReg;
        if (FlushE) begin
            stateNext = IDLE;
        end else begin
            case (stateReg)
                IDLE: begin
                    if (startMul) stateNext = MUL;
`ifdef MIPS_MDU_DIV_EN
                    else if (startDiv) stateNext = divByZero ? DONE : DIV;
`endif
                end
                MUL:  if (lastIter) stateNext = DONE;
`ifdef MIPS_MDU_DIV_EN
                DIV:  if (lastIter) stateNext = DONE;
`endif
                DONE:    stateNext = IDLE;
                default: stateNext = IDLE;
            endcase
        end
    end

    // A flush in DONE cancels the write-back, so the pulse is withheld too.
    always_comb begin
        DoneE = (stateReg == DONE) && !FlushE;
    end

    assign BusyE = busyReg;
    assign HI    = hiReg;
    assign LO    = loReg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cntReg   <= 6'd0;
            accReg   <= 64'd0;
            opndReg  <= 32'd0;
            negLoReg <= 1'b0;
            hiReg    <= 32'd0;
            loReg    <= 32'd0;
`ifdef MIPS_MDU_DIV_EN
            negHiReg <= 1'b0;
            isDivReg <= 1'b0;
`endif
        end else begin
            if (accept && MdOpE == OP_MTHI) hiReg <= SrcAE;
            if (accept && MdOpE == OP_MTLO) loReg <= SrcAE;

            if (startMul) begin
                accReg   <= {32'd0, magB};
                opndReg  <= magA;
                cntReg   <= 6'd0;
                negLoReg <= opSigned & (SrcAE[31] ^ SrcBE[31]);
`ifdef MIPS_MDU_DIV_EN
                isDivReg <= 1'b0;
            end else if (startDiv) begin
                cntReg   <= 6'd0;
                isDivReg <= 1'b1;
                if (divByZero) begin
                    accReg   <= {SrcAE, 32'hFFFF_FFFF};
                    negLoReg <= 1'b0;
                    negHiReg <= 1'b0;
                end else begin
                    accReg   <= {32'd0, magA};
                    opndReg  <= magB;
                    negLoReg <= opSigned & (SrcAE[31] ^ SrcBE[31]);
                    negHiReg <= opSigned & SrcAE[31];
                end
            end else if (stateReg == DIV) begin
                accReg <= divStep;
                cntReg <= cntReg + 6'd1;
`endif
            end else if (stateReg == MUL) begin
                accReg <= mulStep;
                cntReg <= cntReg + 6'd1;
            end

            if (DoneE) begin
                hiReg <= resHi;
                loReg <= resLo;
            end
        end
    end
endmodule
